cas_recorder: RTL and testbench

CAS_RECORDER -- requirements
Module: cas_recorder

---
 rtl/cas_pkg.sv | 22 ++
 rtl/cas_period_meter.sv | 58 +++++
 rtl/cas_recorder.sv | 235 +++++++++++++++++++++++
 tb/tb_cas_recorder.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cas_pkg.sv
// Shared definitions for the MSX cassette recorder and player: FSM states,
// the 8-byte CAS block header and default FSK timing thresholds.
package cas_pkg;

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      SYNC       = 3'd1,
      HDR        = 3'd2,
      WAIT_START = 3'd3,
      DATA       = 3'd4,
      STOP       = 3'd5
   } cas_state_t;

   localparam logic [7:0] CAS_HDR [8] = '{
      8'h1F, 8'hA6, 8'hDE, 8'hBA, 8'hCC, 8'h13, 8'h7D, 8'h74
   };

   localparam int SHORT_MAX_DEF = 3356;
   localparam int MIN_CYC_DEF   = 1000;
   localparam int SYNC_CNT_DEF  = 256;

endpackage

// File: rtl/cas_period_meter.sv
// Measures the length of each cas_in cycle (rising edge to rising edge) in
// ce_5m3 ticks, filters glitches and classifies cycles as short or long.
module cas_period_meter
   import cas_pkg::*;
#(
   parameter int SHORT_MAX = SHORT_MAX_DEF,
   parameter int MIN_CYC   = MIN_CYC_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic ce_5m3,
   input  logic cas_in,
   output logic cyc_valid,
   output logic cyc_short,
   output logic gap
);

   localparam logic [12:0] CNT_SAT   = 13'h1FFF;
   localparam logic [12:0] MIN_LEN   = 13'(MIN_CYC);
   localparam logic [12:0] SHORT_LEN = 13'(SHORT_MAX);

   logic        sync_1;
   logic        sync_2;
   logic        level_q;
   logic [12:0] cnt;
   logic        rise;

   assign rise = sync_2 & ~level_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_1    <= 1'b0;
         sync_2    <= 1'b0;
         level_q   <= 1'b0;
         cnt       <= '0;
         cyc_valid <= 1'b0;
         cyc_short <= 1'b0;
         gap       <= 1'b0;
      end else begin
         sync_1    <= cas_in;
         sync_2    <= sync_1;
         level_q   <= sync_2;
         cyc_valid <= 1'b0;
         gap       <= 1'b0;
         // An edge arriving too early is a glitch: it neither restarts nor
         // reports, so the surrounding cycle is still measured end to end.
         if (rise && cnt >= MIN_LEN) begin
            cyc_valid <= 1'b1;
            cyc_short <= (cnt <= SHORT_LEN);
            cnt       <= '0;
         end else if (ce_5m3 && cnt != CNT_SAT) begin
            cnt <= cnt + 13'd1;
            gap <= (cnt == CNT_SAT - 13'd1);
         end
      end
   end

endmodule

// File: rtl/cas_recorder.sv
// Decodes MSX 1200-baud FSK from cas_in into a CAS byte stream and writes it
// to an external buffer through a 2-entry FIFO and a ram_wr/ready handshake.
module cas_recorder
   import cas_pkg::*;
#(
   parameter int SHORT_MAX = SHORT_MAX_DEF,
   parameter int MIN_CYC   = MIN_CYC_DEF,
   parameter int SYNC_CNT  = SYNC_CNT_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ce_5m3,
   input  logic        record,
   input  logic        cas_in,
   input  logic        rewind,
   output logic [26:0] ram_a,
   output logic [7:0]  ram_do,
   output logic        ram_wr,
   input  logic        buff_mem_ready,
   output logic [26:0] rec_len,
   output logic        overrun,
   output cas_state_t  state
);

   localparam int SW = $clog2(SYNC_CNT + 1);

   logic cyc_valid;
   logic cyc_short;
   logic gap;
   logic is_short;
   logic is_long;

   cas_period_meter #(
      .SHORT_MAX (SHORT_MAX),
      .MIN_CYC   (MIN_CYC)
   ) u_meter (
      .clk       (clk),
      .reset     (reset),
      .ce_5m3    (ce_5m3),
      .cas_in    (cas_in),
      .cyc_valid (cyc_valid),
      .cyc_short (cyc_short),
      .gap       (gap)
   );

   assign is_short = cyc_valid & cyc_short;
   assign is_long  = cyc_valid & ~cyc_short;

   cas_state_t    state_q, state_d;
   logic [SW-1:0] sync_q, sync_d;
   logic [2:0]    hdr_q, hdr_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic          half_q, half_d;
   logic [1:0]    stop_q, stop_d;
   logic          push;
   logic [7:0]    push_data;

   logic [7:0] mem [2];
   logic       rd_q;
   logic       wr_ptr_q;
   logic [1:0] count_q;
   logic       wr_q;
   logic       rew_pend_q;
   logic       full;
   logic       pop;
   logic       accept;
   logic       ovf;
   logic       clear;
   logic [2:0] tail_lo;

   assign state  = state_q;
   assign ram_wr = wr_q;
   assign ram_do = mem[rd_q];

   // Handshake: ram_wr high means ram_a/ram_do hold a valid byte and stay
   // frozen; the byte is taken on the first clk where buff_mem_ready is also
   // high, after which ram_wr drops for one clk and ram_a advances.
   assign full    = (count_q == 2'd2);
   assign pop     = wr_q & buff_mem_ready;
   assign accept  = push & (~full | pop);
   assign ovf     = push & full & ~pop;
   assign clear   = (rewind | rew_pend_q) & (count_q == 2'd0) & ~wr_q;
   assign tail_lo = ram_a[2:0] + {1'b0, count_q};

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         sync_q  <= '0;
         hdr_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         half_q  <= 1'b0;
         stop_q  <= '0;
      end else begin
         state_q <= state_d;
         sync_q  <= sync_d;
         hdr_q   <= hdr_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         half_q  <= half_d;
         stop_q  <= stop_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      sync_d    = sync_q;
      hdr_d     = hdr_q;
      bit_d     = bit_q;
      shift_d   = shift_q;
      half_d    = half_q;
      stop_d    = stop_q;
      push      = 1'b0;
      push_data = 8'h00;
      if (!record) begin
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE: begin
               state_d = SYNC;
               sync_d  = '0;
            end
            SYNC: begin
               if (is_short) begin
                  if (sync_q == SW'(SYNC_CNT - 1)) begin
                     state_d = HDR;
                     hdr_d   = '0;
                  end else begin
                     sync_d = sync_q + SW'(1);
                  end
               end else if (is_long || gap) begin
                  sync_d = '0;
               end
            end
            HDR: begin
               // Pad to an 8-byte boundary of the address the next push lands on.
               if (!full) begin
                  push = 1'b1;
                  if (hdr_q == 3'd0 && tail_lo != 3'd0) begin
                     push_data = 8'h00;
                  end else begin
                     push_data = CAS_HDR[hdr_q];
                     hdr_d     = hdr_q + 3'd1;
                     if (hdr_q == 3'd7) state_d = WAIT_START;
                  end
               end
            end
            WAIT_START: begin
               if (gap) begin
                  state_d = SYNC;
                  sync_d  = '0;
               end else if (is_long) begin
                  state_d = DATA;
                  bit_d   = '0;
                  half_d  = 1'b0;
               end
            end
            DATA: begin
               if (gap || (is_long && half_q)) begin
                  state_d = SYNC;
                  sync_d  = '0;
               end else if (is_long || (is_short && half_q)) begin
                  shift_d = {is_short, shift_q[7:1]};
                  half_d  = 1'b0;
                  bit_d   = bit_q + 3'd1;
                  if (bit_q == 3'd7) begin
                     state_d = STOP;
                     stop_d  = '0;
                  end
               end else if (is_short) begin
                  half_d = 1'b1;
               end
            end
            STOP: begin
               if (gap || is_long) begin
                  state_d = SYNC;
                  sync_d  = '0;
               end else if (is_short) begin
                  stop_d = stop_q + 2'd1;
                  if (stop_q == 2'd3) begin
                     push      = 1'b1;
                     push_data = shift_q;
                     state_d   = WAIT_START;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mem[0]     <= 8'h00;
         mem[1]     <= 8'h00;
         rd_q       <= 1'b0;
         wr_ptr_q   <= 1'b0;
         count_q    <= 2'd0;
         wr_q       <= 1'b0;
         ram_a      <= '0;
         rec_len    <= '0;
         overrun    <= 1'b0;
         rew_pend_q <= 1'b0;
      end else begin
         if (accept) begin
            mem[wr_ptr_q] <= push_data;
            wr_ptr_q      <= ~wr_ptr_q;
         end
         if (pop) begin
            rd_q    <= ~rd_q;
            ram_a   <= ram_a + 27'd1;
            rec_len <= ram_a + 27'd1;
         end
         case ({accept, pop})
            2'b10:   count_q <= count_q + 2'd1;
            2'b01:   count_q <= count_q - 2'd1;
            default: count_q <= count_q;
         endcase
         if (pop) wr_q <= 1'b0;
         else if (count_q != 2'd0) wr_q <= 1'b1;
         // Rewind waits until the buffer side is quiet so no write straddles it.
         if (clear) begin
            ram_a      <= '0;
            rec_len    <= '0;
            overrun    <= 1'b0;
            rew_pend_q <= 1'b0;
         end else if (rewind) begin
            rew_pend_q <= 1'b1;
         end
         if (ovf) overrun <= 1'b1;
      end
   end

endmodule

// File: tb/tb_cas_recorder.sv
// Directed bench for cas_recorder: drives FSK cycles in ce_5m3 ticks and checks
// every buffer write against an address/data expectation queue.
module tb_cas_recorder;
   import cas_pkg::*;

   localparam int SHORT_T = 20;
   localparam int LONG_T  = 40;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        ce_5m3 = 1'b0;
   logic        record = 1'b0;
   logic        cas_in = 1'b0;
   logic        rewind = 1'b0;
   logic        buff_mem_ready = 1'b1;
   logic [26:0] ram_a;
   logic [7:0]  ram_do;
   logic        ram_wr;
   logic [26:0] rec_len;
   logic        overrun;
   cas_state_t  state;

   cas_recorder #(
      .SHORT_MAX (30),
      .MIN_CYC   (10),
      .SYNC_CNT  (256)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .ce_5m3         (ce_5m3),
      .record         (record),
      .cas_in         (cas_in),
      .rewind         (rewind),
      .ram_a          (ram_a),
      .ram_do         (ram_do),
      .ram_wr         (ram_wr),
      .buff_mem_ready (buff_mem_ready),
      .rec_len        (rec_len),
      .overrun        (overrun),
      .state          (state)
   );

   always #5 clk = ~clk;

   initial begin
      int k;
      k = 0;
      forever begin
         @(posedge clk);
         #1;
         ce_5m3 = ((k % 4) != 3);
         k++;
      end
   end

   int checks = 0;
   int errors = 0;
   logic [34:0] exp_q [$];
   logic [26:0] next_addr = '0;
   logic [7:0]  hdr_bytes [8] = '{8'h1F, 8'hA6, 8'hDE, 8'hBA, 8'hCC, 8'h13, 8'h7D, 8'h74};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic exp_push(input logic [7:0] d);
      exp_q.push_back({next_addr, d});
      next_addr = next_addr + 27'd1;
   endtask

   task automatic exp_hdr();
      int pads;
      pads = (8 - int'(next_addr[2:0])) % 8;
      for (int i = 0; i < pads; i++) exp_push(8'h00);
      for (int i = 0; i < 8; i++) exp_push(hdr_bytes[i]);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         while (ce_5m3 !== 1'b1) @(posedge clk);
      end
      #1;
   endtask

   task automatic cyc(input int n);
      cas_in = 1'b1;
      ticks(n / 2);
      cas_in = 1'b0;
      ticks(n - n / 2);
   endtask

   task automatic cyc_long(input bit glitch);
      if (glitch) begin
         cas_in = 1'b1;
         ticks(3);
         cas_in = 1'b0;
         ticks(4);
         cas_in = 1'b1;
         ticks(13);
         cas_in = 1'b0;
         ticks(20);
      end else begin
         cyc(LONG_T);
      end
   endtask

   task automatic tone(input int n);
      for (int i = 0; i < n; i++) cyc(SHORT_T);
   endtask

   task automatic send_byte(input logic [7:0] b, input bit glitch);
      cyc_long(1'b0);
      for (int i = 0; i < 8; i++) begin
         if (b[i]) begin
            cyc(SHORT_T);
            cyc(SHORT_T);
         end else begin
            cyc_long(glitch);
         end
      end
      tone(4);
      tone(2);
   endtask

   // Every buffer write is matched against the expectation queue; the clk
   // after a write must show ram_wr low and the advanced length.
   initial begin
      logic [34:0] ent;
      logic        pend_post;
      logic        pend_stab;
      logic [26:0] post_len;
      logic [26:0] stab_a;
      logic [7:0]  stab_d;
      pend_post = 1'b0;
      pend_stab = 1'b0;
      post_len  = '0;
      stab_a    = '0;
      stab_d    = '0;
      forever begin
         @(negedge clk);
         if (reset) begin
            pend_post = 1'b0;
            pend_stab = 1'b0;
         end else begin
            if (pend_post) begin
               chk("rec_len_after_write", 32'(rec_len), 32'(post_len));
               chk("ram_a_after_write", 32'(ram_a), 32'(post_len));
               chk("ram_wr_drop", 32'(ram_wr), 32'd0);
               pend_post = 1'b0;
            end
            if (pend_stab) begin
               chk("ram_wr_held", 32'(ram_wr), 32'd1);
               chk("ram_a_stable", 32'(ram_a), 32'(stab_a));
               chk("ram_do_stable", 32'(ram_do), 32'(stab_d));
               pend_stab = 1'b0;
            end
            if (ram_wr && buff_mem_ready) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_write_addr", 32'(ram_a), 32'h7FFFFFFF);
               end else begin
                  ent = exp_q.pop_front();
                  chk("write_addr", 32'(ram_a), 32'(ent[34:8]));
                  chk("write_data", 32'(ram_do), 32'(ent[7:0]));
                  post_len  = ent[34:8] + 27'd1;
                  pend_post = 1'b1;
               end
            end else if (ram_wr) begin
               stab_a    = ram_a;
               stab_d    = ram_do;
               pend_stab = 1'b1;
            end
         end
      end
   end

   initial begin
      #3000000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin
      repeat (4) @(posedge clk);
      #1;
      reset = 1'b0;
      chk("reset_ram_wr", 32'(ram_wr), 32'd0);
      chk("reset_ram_a", 32'(ram_a), 32'd0);
      chk("reset_ram_do", 32'(ram_do), 32'd0);
      chk("reset_rec_len", 32'(rec_len), 32'd0);
      chk("reset_overrun", 32'(overrun), 32'd0);
      chk("reset_state", 32'(state), 32'(IDLE));

      // Header tone of 300 short cycles, then 0xA5: header at 0..7, A5 at 8
      record = 1'b1;
      @(posedge clk);
      #1;
      chk("idle_to_sync", 32'(state), 32'(SYNC));
      exp_hdr();
      exp_push(8'hA5);
      tone(300);
      send_byte(8'hA5, 1'b0);
      chk("t1_rec_len", 32'(rec_len), 32'd9);

      // Buffer stalled while 3 bytes decode: first two kept, third lost
      buff_mem_ready = 1'b0;
      exp_push(8'h11);
      exp_push(8'h22);
      send_byte(8'h11, 1'b0);
      send_byte(8'h22, 1'b0);
      send_byte(8'h33, 1'b0);
      chk("t2_overrun", 32'(overrun), 32'd1);
      chk("t2_ram_wr", 32'(ram_wr), 32'd1);
      chk("t2_ram_a_held", 32'(ram_a), 32'd9);
      buff_mem_ready = 1'b1;
      tone(4);
      chk("t2_rec_len", 32'(rec_len), 32'd11);

      // Pointer at 11 (3 mod 8): five pads at 11..15, header at 16..23
      record = 1'b0;
      @(posedge clk);
      #1;
      chk("t3_idle", 32'(state), 32'(IDLE));
      record = 1'b1;
      exp_hdr();
      tone(270);
      chk("t3_rec_len", 32'(rec_len), 32'd24);

      // Single short then long inside DATA: framing error, back to SYNC
      cyc(LONG_T);
      cyc(SHORT_T);
      cyc(LONG_T);
      cyc(SHORT_T);
      chk("t4_sync", 32'(state), 32'(SYNC));
      exp_hdr();
      tone(270);
      chk("t4_rec_len", 32'(rec_len), 32'd32);
      chk("t4_wait_start", 32'(state), 32'(WAIT_START));

      // Glitch pulses inside every long data cycle still decode as 0 bits
      exp_push(8'h96);
      send_byte(8'h96, 1'b1);
      chk("t5_rec_len", 32'(rec_len), 32'd33);

      // Record dropped mid-byte, then rewind while a write is pending
      buff_mem_ready = 1'b0;
      exp_push(8'h3C);
      send_byte(8'h3C, 1'b0);
      chk("t6_ram_wr", 32'(ram_wr), 32'd1);
      chk("t6_ram_a", 32'(ram_a), 32'd33);
      cyc(LONG_T);
      cyc(LONG_T);
      record = 1'b0;
      @(posedge clk);
      #1;
      chk("t6_idle", 32'(state), 32'(IDLE));
      rewind = 1'b1;
      @(posedge clk);
      #1;
      rewind = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      chk("t6_rewind_deferred", 32'(ram_a), 32'd33);
      buff_mem_ready = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      next_addr = '0;
      chk("t6_ram_a_cleared", 32'(ram_a), 32'd0);
      chk("t6_rec_len_cleared", 32'(rec_len), 32'd0);
      chk("t6_overrun_cleared", 32'(overrun), 32'd0);
      chk("t6_ram_wr_idle", 32'(ram_wr), 32'd0);
      chk("writes_outstanding", 32'(exp_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
